expr_calc_ctrl: RTL

- Sequencing controller for the character-stream expression path. It accepts an ASCII stream of single-digit operands separated by '+' or '*', terminated by '='.
- It checks the grammar digit((+|*)digit)* on the fly and evaluates the expression with standard precedence ('*' binds tighter than '+').
- It returns the result, or an error flag, through a result handshake. It sits between the character source (UART or testbench feeder) and result consumer logic.

---
 rtl/expr_pkg.sv | 17 +
 rtl/expr_char_class.sv | 24 ++
 rtl/expr_calc_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/expr_pkg.sv
// Shared state encoding and ASCII constants for the expression controller.
package expr_pkg;

  typedef enum logic [1:0] {
    EXP_NUM = 2'd0,
    EXP_OP  = 2'd1,
    ERR     = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;

endpackage

// File: rtl/expr_char_class.sv
// Combinational classifier for one ASCII character of the expression stream.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] in_char,
  output logic       is_digit,
  output logic       is_plus,
  output logic       is_mul,
  output logic       is_eq,
  output logic [3:0] digit
);

  logic [7:0] offset;

  always_comb begin
    offset   = in_char - CH_0;
    is_digit = (in_char >= CH_0) && (in_char <= CH_9);
    is_plus  = (in_char == CH_PLUS);
    is_mul   = (in_char == CH_MUL);
    is_eq    = (in_char == CH_EQ);
    digit    = is_digit ? offset[3:0] : 4'd0;
  end

endmodule

// File: rtl/expr_calc_ctrl.sv
// Grammar-checking evaluator for single-digit '+'/'*' expressions terminated by '='.
// sum holds the finished additive terms, prod the product term currently being built.
module expr_calc_ctrl
  import expr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic             expr_ok,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_value,
  output logic             res_err,
  input  logic             res_ack
);

  state_t           state_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] prod_reg;
  logic             pend_mul_reg;

  logic       is_digit;
  logic       is_plus;
  logic       is_mul;
  logic       is_eq;
  logic [3:0] digit;
  logic       accept;

  expr_char_class u_class (
    .in_char  (in_char),
    .is_digit (is_digit),
    .is_plus  (is_plus),
    .is_mul   (is_mul),
    .is_eq    (is_eq),
    .digit    (digit)
  );

  assign in_ready = (state_reg != DONE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg    <= EXP_NUM;
      sum_reg      <= '0;
      prod_reg     <= '0;
      pend_mul_reg <= 1'b0;
      expr_ok      <= 1'b0;
      res_valid    <= 1'b0;
      res_value    <= '0;
      res_err      <= 1'b0;
    end else begin
      case (state_reg)
        EXP_NUM: if (accept) begin
          if (is_digit) begin
            prod_reg  <= pend_mul_reg ? prod_reg * WIDTH'(digit) : WIDTH'(digit);
            expr_ok   <= 1'b1;
            state_reg <= EXP_OP;
          end else if (is_eq) begin
            // empty expression or dangling operator
            res_err   <= 1'b1;
            res_value <= '0;
            res_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            expr_ok   <= 1'b0;
            state_reg <= ERR;
          end
        end
        EXP_OP: if (accept) begin
          if (is_plus) begin
            sum_reg      <= sum_reg + prod_reg;
            pend_mul_reg <= 1'b0;
            expr_ok      <= 1'b0;
            state_reg    <= EXP_NUM;
          end else if (is_mul) begin
            pend_mul_reg <= 1'b1;
            expr_ok      <= 1'b0;
            state_reg    <= EXP_NUM;
          end else if (is_eq) begin
            res_value <= sum_reg + prod_reg;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            expr_ok   <= 1'b0;
            state_reg <= ERR;
          end
        end
        ERR: if (accept && is_eq) begin
          res_err   <= 1'b1;
          res_value <= '0;
          res_valid <= 1'b1;
          state_reg <= DONE;
        end
        DONE: if (res_ack) begin
          res_valid    <= 1'b0;
          res_err      <= 1'b0;
          res_value    <= '0;
          sum_reg      <= '0;
          prod_reg     <= '0;
          pend_mul_reg <= 1'b0;
          expr_ok      <= 1'b0;
          state_reg    <= EXP_NUM;
        end
        default: state_reg <= EXP_NUM;
      endcase
    end
  end

endmodule
